acc_feeder: RTL and testbench

//   Upstream feeder for the accumulator core. Buffers incoming operands from a

---
 rtl/acc_feeder_pkg.sv | 12 +
 rtl/acc_fifo.sv | 75 +++++++
 rtl/acc_feeder.sv | 104 ++++++++++
 tb/tb_acc_feeder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_feeder_pkg.sv
// Shared definitions for the accumulator feeder: FSM state encoding and default widths.
package acc_feeder_pkg;

  localparam int IN_DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_fifo.sv
// Synchronous operand FIFO with occupancy count, full/empty flags and a
// registered read port. A word written in one cycle is visible to pop only
// from the next cycle on, so there is no write-to-read pass-through.
module acc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array, written on accepted push; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Registered read: the popped word appears on rdata_o the cycle after the pop and holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (pop_ok) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/acc_feeder.sv
// Feeds buffered operands to the accumulator core: on start it issues exactly
// len_i number/valid beats under run_o, with done_o on the final beat.
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 4,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [IN_DATA_WIDTH-1:0]      s_data_i,
  input  logic                          start_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          run_o,
  output logic                          valid_o,
  output logic [IN_DATA_WIDTH-1:0]      number_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 run_q, busy_q, done_q, valid_q;
  logic                 fifo_full, fifo_empty, pop;

  // Drain one operand per cycle while a job is running and data is available.
  assign pop = (state_q == ST_RUN) && !fifo_empty;

  acc_fifo #(
    .WIDTH (IN_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (s_valid_i),
    .wdata_i (s_data_i),
    .pop_i   (pop),
    .rdata_o (number_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_o)
  );

  assign s_ready_o = !fifo_full;

  // Job FSM with remaining-count and registered status/beat outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (len_i != '0) begin
              rem_q   <= len_i;
              run_q   <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              // Empty job completes immediately with no beats and run_o low.
              run_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (pop) begin
            rem_q <= rem_q - 1'b1;
            // The last pop's beat lands together with done_o.
            if (rem_q == LEN_WIDTH'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          run_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign run_o   = run_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_acc_feeder;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [W-1:0]  s_data_i = '0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, run_o, valid_o;
  logic [W-1:0]  number_o;
  logic [CW-1:0] fifo_cnt_o;

  acc_feeder #(
    .IN_DATA_WIDTH (W),
    .FIFO_DEPTH    (D),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .run_o      (run_o),
    .valid_o    (valid_o),
    .number_o   (number_o),
    .fifo_cnt_o (fifo_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operand queue, job phase (0 idle, 1 running, 2 finishing),
  // operands still owed, and the expected registered outputs.
  int unsigned q[$];
  int  m_phase = 0;
  int  m_owed  = 0;
  bit  e_busy = 0, e_done = 0, e_run = 0, e_valid = 0;
  int  e_num = 0;

  int  done_cnt = 0;
  int  acc_sum  = 0;
  int  last_sum = 0;

  task automatic model_edge();
    int  sz;
    bit  popped;
    int unsigned pd;
    popped = 1'b0;
    pd     = 0;
    if (!reset_n) begin
      q.delete();
      m_phase = 0; m_owed = 0;
      e_busy = 0; e_done = 0; e_run = 0; e_valid = 0; e_num = 0;
      return;
    end
    sz = q.size();
    if (m_phase == 1 && sz > 0) begin
      pd = q.pop_front();
      popped = 1'b1;
    end
    if (s_valid_i && sz < D) q.push_back(int'(s_data_i));
    e_valid = popped;
    if (popped) e_num = int'(pd);
    case (m_phase)
      0: begin
        e_done = 0;
        if (start_i) begin
          e_busy = 1;
          if (len_i != 0) begin
            m_phase = 1; m_owed = int'(len_i); e_run = 1;
          end else begin
            m_phase = 2; e_run = 0; e_done = 1;
          end
        end
      end
      1: begin
        if (popped) begin
          m_owed--;
          if (m_owed == 0) begin
            m_phase = 2; e_done = 1;
          end
        end
      end
      default: begin
        m_phase = 0; e_done = 0; e_busy = 0; e_run = 0;
      end
    endcase
  endtask

  // One clock: advance model at the edge, compare #1 later, track jobs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy_o",     32'(busy_o),     32'(e_busy));
    check("done_o",     32'(done_o),     32'(e_done));
    check("run_o",      32'(run_o),      32'(e_run));
    check("valid_o",    32'(valid_o),    32'(e_valid));
    check("number_o",   32'(number_o),   32'(e_num));
    check("fifo_cnt_o", 32'(fifo_cnt_o), 32'(q.size()));
    check("s_ready_o",  32'(s_ready_o),  32'(q.size() != D));
    if (!reset_n) begin
      acc_sum = 0;
    end else begin
      if (valid_o) acc_sum += int'(number_o);
      if (done_o) begin
        last_sum = acc_sum;
        acc_sum  = 0;
        done_cnt++;
        $display("[TB] job complete @%0t sum=%0d fifo=%0d", $time, last_sum, fifo_cnt_o);
      end
    end
  endtask

  task automatic cyc(input bit sv, input int d, input bit st, input int ln);
    s_valid_i = sv;
    s_data_i  = W'(d);
    start_i   = st;
    len_i     = LW'(ln);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    // Power-up reset and reset values.
    reset_n = 1'b0;
    idle(2);
    check("rst_number", 32'(number_o), 32'd0);
    check("rst_ready",  32'(s_ready_o), 32'd1);
    reset_n = 1'b1;

    // 1. Reset during RUN drops the job.
    done_cnt = 0;
    cyc(1, 10, 0, 0);
    cyc(1, 20, 0, 0);
    cyc(0, 0, 1, 5);
    idle(2);
    reset_n = 1'b0;
    idle(1);
    check("t1_run",  32'(run_o),      32'd0);
    check("t1_cnt",  32'(fifo_cnt_o), 32'd0);
    check("t1_busy", 32'(busy_o),     32'd0);
    reset_n = 1'b1;
    idle(3);
    check("t1_nodone", 32'(done_cnt), 32'd0);

    // 2. Three buffered operands, accumulator result 15.
    cyc(1, 3, 0, 0);
    cyc(1, 5, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(0, 0, 1, 3);
    idle(5);
    check("t2_sum",   32'(last_sum), 32'd15);
    check("t2_dones", 32'(done_cnt), 32'd1);

    // 3. Start on an empty FIFO, operands trickle in with gaps.
    done_cnt = 0;
    cyc(0, 0, 1, 4);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, k, 0, 0);
      idle(2);
    end
    idle(3);
    check("t3_dones", 32'(done_cnt), 32'd1);
    check("t3_sum",   32'(last_sum), 32'd10);

    // 4. Fill the FIFO, fifth operand held off, partial drain.
    for (int k = 0; k < 4; k++) cyc(1, 11 + k, 0, 0);
    cyc(1, 99, 0, 0);
    check("t4_full_ready", 32'(s_ready_o),  32'd0);
    check("t4_full_cnt",   32'(fifo_cnt_o), 32'd4);
    cyc(0, 0, 1, 2);
    idle(4);
    check("t4_left_cnt", 32'(fifo_cnt_o), 32'd2);
    check("t4_ready",    32'(s_ready_o),  32'd1);
    check("t4_sum",      32'(last_sum),   32'd23);
    cyc(0, 0, 1, 2);
    idle(4);

    // 5. Zero-length job.
    cyc(1, 42, 0, 0);
    cyc(0, 0, 1, 0);
    check("t5_done",  32'(done_o),     32'd1);
    check("t5_run",   32'(run_o),      32'd0);
    check("t5_valid", 32'(valid_o),    32'd0);
    check("t5_cnt",   32'(fifo_cnt_o), 32'd1);
    idle(2);
    cyc(0, 0, 1, 1);
    idle(3);

    // 6. start_i during RUN and in the DONE cycle is ignored.
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 2);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 3);
    check("t6_done", 32'(done_o), 32'd1);
    cyc(0, 0, 1, 0);
    check("t6_idle_busy", 32'(busy_o), 32'd0);
    check("t6_idle_done", 32'(done_o), 32'd0);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)));
    end
    reset_n = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
